alu: RTL and testbench

16-bit combinational arithmetic/logic unit with a registered completion strobe, used as the execute stage of the processor datapath. It takes a 6-bit opcode and two 16-bit signed operands and produces a 16-bit result plus zero/negative/carry/overflow flags. The result path is purely combinational: a value is valid in the same cycle the inputs are applied, even with the clock stopped. Only `done` is clocked.

---
 rtl/alu.sv | 148 ++++++++++++++
 tb/tb_alu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit execute-stage ALU: combinational result and flags, plus a registered
// completion strobe that follows alu_enable one clock later.
module alu (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        alu_enable,
  input  logic [5:0]  opcode,
  input  logic [15:0] term1,
  input  logic [15:0] term2,
  output logic [15:0] result,
  output logic        fl_zero,
  output logic        fl_negative,
  output logic        fl_carry,
  output logic        fl_overflow,
  output logic        done
);

  typedef enum logic [5:0] {
    OP_ADD = 6'h00,
    OP_SUB = 6'h01,
    OP_MUL = 6'h02,
    OP_DIV = 6'h03,
    OP_MOD = 6'h04,
    OP_AND = 6'h05,
    OP_OR  = 6'h06,
    OP_XOR = 6'h07,
    OP_NOT = 6'h08,
    OP_CMP = 6'h09,
    OP_MOV = 6'h0A,
    OP_RSR = 6'h0B
  } opcode_e;

  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [31:0] prod;
  logic        [16:0] sum;
  logic        [15:0] diff;
  logic               borrow;
  logic               add_ovf;
  logic               sub_ovf;
  logic               mul_wide;
  logic               div_zero;
  logic               div_ovf;
  logic signed [15:0] divisor;
  logic signed [15:0] quot;
  logic signed [15:0] rem;
  logic        [3:0]  rot_amt;
  logic        [15:0] rot;

  logic [15:0] res;
  logic        carry;
  logic        ovf;
  logic        defined;
  logic        is_cmp;

  assign a        = $signed(term1);
  assign b        = $signed(term2);
  assign sum      = {1'b0, term1} + {1'b0, term2};
  assign diff     = term1 - term2;
  assign borrow   = term1 < term2;
  assign add_ovf  = (term1[15] == term2[15]) && (sum[15] != term1[15]);
  assign sub_ovf  = (term1[15] != term2[15]) && (diff[15] != term1[15]);
  assign prod     = 32'(a) * 32'(b);
  assign mul_wide = prod[31:16] != {16{prod[15]}};

  // Divisor is forced to 1 on the guarded cases so the divider never sees /0.
  assign div_zero = term2 == '0;
  assign div_ovf  = (term1 == 16'h8000) && (term2 == 16'hFFFF);
  assign divisor  = (div_zero || div_ovf) ? 16'sd1 : b;
  assign quot     = a / divisor;
  assign rem      = a % divisor;

  assign rot_amt  = term1[3:0];
  assign rot      = (term2 >> rot_amt) | (term2 << (5'd16 - {1'b0, rot_amt}));

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    defined = 1'b1;
    is_cmp  = 1'b0;
    case (opcode)
      OP_ADD: begin
        res   = sum[15:0];
        carry = sum[16];
        ovf   = add_ovf;
      end
      OP_SUB: begin
        res   = diff;
        carry = borrow;
        ovf   = sub_ovf;
      end
      OP_MUL: begin
        res   = prod[15:0];
        carry = mul_wide;
        ovf   = mul_wide;
      end
      OP_DIV: begin
        if (div_zero) begin
          ovf = 1'b1;
        end else if (div_ovf) begin
          res = 16'h8000;
          ovf = 1'b1;
        end else begin
          res = quot;
        end
      end
      OP_MOD: begin
        if (div_zero || div_ovf) begin
          ovf = 1'b1;
        end else begin
          res = rem;
        end
      end
      OP_AND: res = term1 & term2;
      OP_OR:  res = term1 | term2;
      OP_XOR: res = term1 ^ term2;
      OP_NOT: res = ~term1;
      OP_CMP: begin
        is_cmp = 1'b1;
        carry  = borrow;
        ovf    = sub_ovf;
      end
      OP_MOV: res = term2;
      OP_RSR: begin
        res   = rot;
        carry = (rot_amt != '0) && rot[15];
      end
      default: defined = 1'b0;
    endcase
  end

  // CMP reports sign and equality of the difference while result stays zero.
  assign result      = alu_enable ? res : '0;
  assign fl_zero     = alu_enable && defined && (is_cmp ? (term1 == term2) : (res == '0));
  assign fl_negative = alu_enable && (is_cmp ? diff[15] : res[15]);
  assign fl_carry    = alu_enable && carry;
  assign fl_overflow = alu_enable && ovf;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      done <= 1'b0;
    end else begin
      done <= alu_enable;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, random vectors against an
// integer-arithmetic reference model, enable gating and the done strobe.
module tb_alu;

  logic        clk;
  logic        rst_b;
  logic        alu_enable;
  logic [5:0]  opcode;
  logic [15:0] term1;
  logic [15:0] term2;
  logic [15:0] result;
  logic        fl_zero;
  logic        fl_negative;
  logic        fl_carry;
  logic        fl_overflow;
  logic        done;

  int checks;
  int failures;

  alu dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .alu_enable  (alu_enable),
    .opcode      (opcode),
    .term1       (term1),
    .term2       (term2),
    .result      (result),
    .fl_zero     (fl_zero),
    .fl_negative (fl_negative),
    .fl_carry    (fl_carry),
    .fl_overflow (fl_overflow),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {result, zero, negative, carry, overflow}.
  function automatic logic [19:0] model(input logic [5:0] op, input logic [15:0] t1,
                                        input logic [15:0] t2);
    int sa;
    int sb;
    int ua;
    int ub;
    int x;
    logic [15:0] r;
    logic [15:0] d16;
    bit z;
    bit n;
    bit c;
    bit v;
    bit def;
    sa  = int'($signed(t1));
    sb  = int'($signed(t2));
    ua  = int'(t1);
    ub  = int'(t2);
    r   = 16'h0000;
    c   = 0;
    v   = 0;
    def = 1;
    x   = 0;
    case (op)
      6'h00: begin x = sa + sb; r = 16'(x); c = (ua + ub) > 65535; v = (x > 32767) || (x < -32768); end
      6'h01: begin x = sa - sb; r = 16'(x); c = ua < ub; v = (x > 32767) || (x < -32768); end
      6'h02: begin x = sa * sb; r = 16'(x); c = (x > 32767) || (x < -32768); v = c; end
      6'h03: begin
        if (sb == 0) v = 1;
        else if (sa == -32768 && sb == -1) begin r = 16'h8000; v = 1; end
        else r = 16'(sa / sb);
      end
      6'h04: begin
        if (sb == 0 || (sa == -32768 && sb == -1)) v = 1;
        else r = 16'(sa % sb);
      end
      6'h05: r = t1 & t2;
      6'h06: r = t1 | t2;
      6'h07: r = t1 ^ t2;
      6'h08: r = ~t1;
      6'h09: begin x = sa - sb; r = 16'h0000; c = ua < ub; v = (x > 32767) || (x < -32768); end
      6'h0A: r = t2;
      6'h0B: begin
        r = t2;
        for (int i = 0; i < int'(t1[3:0]); i++) r = {r[0], r[15:1]};
        c = (t1[3:0] != 4'd0) && r[15];
      end
      default: def = 0;
    endcase
    z = def && (r == 16'h0000);
    n = r[15];
    if (op == 6'h09) begin
      d16 = 16'(sa - sb);
      z = (t1 == t2);
      n = d16[15];
    end
    return {r, z, n, c, v};
  endfunction

  task automatic test_reset();
    rst_b      = 1'b0;
    alu_enable = 1'b1;
    opcode     = 6'h00;
    term1      = 16'd1;
    term2      = 16'd2;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (result !== 16'd3) begin
      failures++;
      $display("FAIL reset_result_tracks: got %h expected 0003", result);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] r;
    logic [3:0]  f; // {z, n, c, v}
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    tbl.push_back('{6'h00, 16'h0005, 16'h000A, 16'h000F, 4'b0000});
    tbl.push_back('{6'h00, 16'hFFF4, 16'h000A, 16'hFFFE, 4'b0100});
    tbl.push_back('{6'h00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101});
    tbl.push_back('{6'h01, 16'h0010, 16'h000A, 16'h0006, 4'b0000});
    tbl.push_back('{6'h01, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110});
    tbl.push_back('{6'h01, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001});
    tbl.push_back('{6'h02, 16'h0005, 16'h000A, 16'h0032, 4'b0000});
    tbl.push_back('{6'h02, 16'hFFFF, 16'h000A, 16'hFFF6, 4'b0100});
    tbl.push_back('{6'h02, 16'h0100, 16'h0100, 16'h0000, 4'b1011});
    tbl.push_back('{6'h09, 16'h0030, 16'h0020, 16'h0000, 4'b0000});
    tbl.push_back('{6'h09, 16'h1234, 16'h1234, 16'h0000, 4'b1000});
    tbl.push_back('{6'h03, 16'd30,   16'd3,    16'h000A, 4'b0000});
    tbl.push_back('{6'h04, 16'd30,   16'd3,    16'h0000, 4'b1000});
    tbl.push_back('{6'h04, 16'd30,   16'd7,    16'h0002, 4'b0000});
    tbl.push_back('{6'h04, 16'hFFF9, 16'h0002, 16'hFFFF, 4'b0100});
    tbl.push_back('{6'h03, 16'h1234, 16'h0000, 16'h0000, 4'b1001});
    tbl.push_back('{6'h03, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101});
    tbl.push_back('{6'h04, 16'h8000, 16'hFFFF, 16'h0000, 4'b1001});
    tbl.push_back('{6'h05, 16'h00F0, 16'h0F00, 16'h0000, 4'b1000});
    tbl.push_back('{6'h06, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000});
    tbl.push_back('{6'h07, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000});
    tbl.push_back('{6'h08, 16'h00F0, 16'h0F00, 16'hFF0F, 4'b0100});
    tbl.push_back('{6'h0A, 16'h5555, 16'h00AA, 16'h00AA, 4'b0000});
    tbl.push_back('{6'h0B, 16'h0004, 16'h0F00, 16'h00F0, 4'b0000});
    tbl.push_back('{6'h0B, 16'h0001, 16'h0001, 16'h8000, 4'b0110});
    tbl.push_back('{6'h0B, 16'hFFF0, 16'h8001, 16'h8001, 4'b0100});
    tbl.push_back('{6'h3F, 16'h1234, 16'h5678, 16'h0000, 4'b0000});
    tbl.push_back('{6'h0C, 16'h0000, 16'h0000, 16'h0000, 4'b0000});
    alu_enable = 1'b1;
    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      term1  = tbl[i].t1;
      term2  = tbl[i].t2;
      #1;
      checks++;
      if (result !== tbl[i].r) begin
        failures++;
        $display("FAIL directed_result[%0d] op=%h: got %h expected %h", i, opcode, result, tbl[i].r);
      end
      checks++;
      if ({fl_zero, fl_negative, fl_carry, fl_overflow} !== tbl[i].f) begin
        failures++;
        $display("FAIL directed_flags[%0d] op=%h: got zncv=%b expected %b", i, opcode,
                 {fl_zero, fl_negative, fl_carry, fl_overflow}, tbl[i].f);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] exp;
    alu_enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(12, 63)) : 6'($urandom_range(0, 11));
      term1  = 16'($urandom);
      term2  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        term1 = 16'h8000;
        term2 = 16'hFFFF;
      end
      #1;
      exp = model(opcode, term1, term2);
      checks++;
      if ({result, fl_zero, fl_negative, fl_carry, fl_overflow} !== exp) begin
        failures++;
        $display("FAIL random[%0d] op=%h t1=%h t2=%h: got r=%h zncv=%b expected r=%h zncv=%b",
                 i, opcode, term1, term2, result,
                 {fl_zero, fl_negative, fl_carry, fl_overflow}, exp[19:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_enable();
    alu_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      opcode = (i < 2) ? 6'h09 : 6'($urandom_range(0, 11));
      term1  = 16'($urandom);
      term2  = (i == 0) ? term1 : 16'($urandom);
      #1;
      checks++;
      if ({result, fl_zero, fl_negative, fl_carry, fl_overflow} !== 20'h00000) begin
        failures++;
        $display("FAIL enable_gating[%0d] op=%h: got r=%h zncv=%b expected all zero", i, opcode,
                 result, {fl_zero, fl_negative, fl_carry, fl_overflow});
      end
    end
  endtask

  task automatic test_done();
    rst_b      = 1'b0;
    alu_enable = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_before_edge: got %b expected 0", done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_first_edge: got %b expected 1", done);
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_async_reset: got %b expected 0", done);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_after_reset: got %b expected 1", done);
    end
    alu_enable = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_holds_until_edge: got %b expected 1", done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_disable: got %b expected 0", done);
    end
    alu_enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_reenable: got %b expected 1", done);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    rst_b = 1'b1;
    test_directed();
    test_random();
    test_enable();
    test_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
